// File: rtl/cnt_seq_ctrl_pkg.sv
// cnt_seq_ctrl_pkg
// Shared definitions for the counter sequencing controller: FSM state
// encodings, run-mode codes and a small helper that gives the initial
// count direction for a mode.
package cnt_seq_ctrl_pkg;

  // Controller states; the encoding is fixed so it can be read from a debug tap.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Run-mode codes as presented on the mode input.
  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;
  localparam logic [1:0] MODE_FREE     = 2'd3;

  // Ping-pong starts counting up and free-run always counts up; the others count down.
  function automatic logic start_dir_up(input logic [1:0] md);
    return (md == MODE_PINGPONG) || (md == MODE_FREE);
  endfunction

endpackage

// File: rtl/updn_cnt_ld.sv
// updn_cnt_ld
// M-bit loadable up/down counter. Priority: clr > L > ce.
// Ports:
//   clk  rising-edge clock
//   clr  asynchronous active-high reset (Q -> 0)
//   ce   count enable
//   up   direction, 1 = count up
//   L    synchronous parallel load of di
//   di   load data
//   Q    counter value
//   TC   terminal count for the current direction (all ones up, zero down)
//   CEO  ce & TC, cascade enable for a following stage
module updn_cnt_ld #(
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ce,
  input  logic         up,
  input  logic         L,
  input  logic [M-1:0] di,
  output logic [M-1:0] Q,
  output logic         TC,
  output logic         CEO
);

  // Count register: load wins over count, reset wins over both.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      Q <= {M{1'b0}};
    end else if (L) begin
      Q <= di;
    end else if (ce) begin
      if (up) begin
        Q <= Q + {{(M-1){1'b0}}, 1'b1};
      end else begin
        Q <= Q - {{(M-1){1'b0}}, 1'b1};
      end
    end else begin
      Q <= Q;
    end
  end

  assign TC  = up ? (&Q) : (~|Q);
  assign CEO = ce & TC;

endmodule

// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl
// Sequencing controller for a loadable up/down counter. Adds a prescaler
// and four run modes (one-shot, periodic reload, ping-pong, free-run) with
// a start/stop/done handshake.
// Ports:
//   clk       rising-edge clock
//   clr       asynchronous active-high reset
//   start     begins a run when idle (level, sampled at posedge)
//   stop      aborts a run in LOAD or RUN (level, sampled at posedge)
//   mode      0 one-shot down, 1 periodic down, 2 ping-pong, 3 free-run up
//   load_val  initial / reload count
//   presc     one counter step every presc+1 cycles
//   q         counter value
//   dir       current count direction (1 = up)
//   busy      controller not idle
//   tick      terminal-event pulse (combinational)
//   done      registered one-cycle pulse at one-shot completion
module cnt_seq_ctrl
  import cnt_seq_ctrl_pkg::*;
#(
  parameter int M  = 4,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic          stop,
  input  logic [1:0]    mode,
  input  logic [M-1:0]  load_val,
  input  logic [PW-1:0] presc,
  output logic [M-1:0]  q,
  output logic          dir,
  output logic          busy,
  output logic          tick,
  output logic          done
);

  state_t        state_r;
  logic [PW-1:0] pcnt_r;
  logic [1:0]    mode_r;
  logic [M-1:0]  load_r;
  logic [PW-1:0] presc_r;
  logic          dir_r;
  logic          done_r;

  logic          en_step_s;
  logic          tc_s;
  logic          term_s;
  logic          ce_s;
  logic          ld_s;
  logic [M-1:0]  di_s;
  logic          tick_s;
  logic [M-1:0]  cnt_q_s;
  logic          cnt_tc_unused_s;
  logic          cnt_ceo_unused_s;

  // The counter's own TC/CEO are not used: TC is recomputed here from dir_r
  // and q so the terminal decision and the direction register never disagree.
  updn_cnt_ld #(.M(M)) u_cnt (
    .clk (clk),
    .clr (clr),
    .ce  (ce_s),
    .up  (dir_r),
    .L   (ld_s),
    .di  (di_s),
    .Q   (cnt_q_s),
    .TC  (cnt_tc_unused_s),
    .CEO (cnt_ceo_unused_s)
  );

  // Counter control decode; stop suppresses any step, load or tick on its edge.
  always_comb begin
    en_step_s = (pcnt_r == presc_r);
    tc_s      = dir_r ? (cnt_q_s == {M{1'b1}}) : (cnt_q_s == {M{1'b0}});
    term_s    = en_step_s & tc_s;
    ce_s      = 1'b0;
    ld_s      = 1'b0;
    di_s      = load_r;
    tick_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ce_s = 1'b0;
      end
      ST_LOAD: begin
        if (stop) begin
          ld_s = 1'b0;
        end else begin
          ld_s = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          ce_s = 1'b0;
        end else begin
          tick_s = term_s;
          case (mode_r)
            MODE_FREE: begin
              // Free-run wraps through the counter's natural rollover.
              ce_s = en_step_s;
            end
            MODE_PERIODIC: begin
              // Reload replaces the step so the count never wraps.
              ce_s = en_step_s & ~tc_s;
              ld_s = term_s;
            end
            default: begin
              // One-shot and ping-pong hold q on the terminal step.
              ce_s = en_step_s & ~tc_s;
            end
          endcase
        end
      end
      default: begin
        ce_s = 1'b0;
      end
    endcase
  end

  // Controller FSM, prescaler, shadow registers and registered flags.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= ST_IDLE;
      pcnt_r  <= {PW{1'b0}};
      mode_r  <= 2'd0;
      load_r  <= {M{1'b0}};
      presc_r <= {PW{1'b0}};
      dir_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && !stop) begin
            state_r <= ST_LOAD;
            mode_r  <= mode;
            load_r  <= load_val;
            presc_r <= presc;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (stop) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_RUN;
            pcnt_r  <= {PW{1'b0}};
            dir_r   <= start_dir_up(mode_r);
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_r <= ST_IDLE;
          end else begin
            if (en_step_s) begin
              pcnt_r <= {PW{1'b0}};
            end else begin
              pcnt_r <= pcnt_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (term_s) begin
              case (mode_r)
                MODE_ONESHOT: begin
                  state_r <= ST_IDLE;
                  done_r  <= 1'b1;
                end
                MODE_PINGPONG: begin
                  dir_r <= ~dir_r;
                end
                default: begin
                  state_r <= ST_RUN;
                end
              endcase
            end else begin
              state_r <= ST_RUN;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign q    = cnt_q_s;
  assign dir  = dir_r;
  assign busy = (state_r != ST_IDLE);
  assign tick = tick_s;
  assign done = done_r;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// tb_cnt_seq_ctrl
// Self-checking bench for cnt_seq_ctrl: hand-derived cycle tables for the
// main mode sequences, asynchronous clear checks, and a reference-model
// scoreboard over boundary and random runs.
module tb_cnt_seq_ctrl;

  logic       clk;
  logic       clr;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [3:0] load_val;
  logic [7:0] presc;
  logic [3:0] q;
  logic       dir;
  logic       busy;
  logic       tick;
  logic       done;

  int total = 0;
  int bad   = 0;

  cnt_seq_ctrl #(.M(4), .PW(8)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .load_val (load_val),
    .presc    (presc),
    .q        (q),
    .dir      (dir),
    .busy     (busy),
    .tick     (tick),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus the outputs expected during that cycle.
  typedef struct {
    logic       st;
    logic       sp;
    logic [1:0] md;
    logic [3:0] ld;
    logic [7:0] ps;
    logic [3:0] eq;
    logic       edir;
    logic       ebusy;
    logic       etick;
    logic       edone;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(input bit st, input bit sp, input int md, input int ld,
                              input int ps, input int eq, input bit ed, input bit eb,
                              input bit et, input bit edn);
    vec_t v;
    v.st = st; v.sp = sp; v.md = 2'(md); v.ld = 4'(ld); v.ps = 8'(ps);
    v.eq = 4'(eq); v.edir = ed; v.ebusy = eb; v.etick = et; v.edone = edn;
    return v;
  endfunction

  task automatic chk(input string tag, input vec_t e);
    total++;
    if (q !== e.eq || dir !== e.edir || busy !== e.ebusy || tick !== e.etick || done !== e.edone) begin
      bad++;
      $display("FAIL %s: got q=%0d dir=%0b busy=%0b tick=%0b done=%0b, want q=%0d dir=%0b busy=%0b tick=%0b done=%0b",
               tag, q, dir, busy, tick, done, e.eq, e.edir, e.ebusy, e.etick, e.edone);
    end
  endtask

  // Drive a vector at the falling edge, queue its expectation, compare 1 time unit later.
  task automatic drive_check(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    start = v.st; stop = v.sp; mode = v.md; load_val = v.ld; presc = v.ps;
    sb.push_back(v);
    #1;
    e = sb.pop_front();
    chk(tag, e);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    clr = 1'b1;
    #2;
    clr = 1'b0;
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      drive_check(tbl[i], $sformatf("%s[%0d]", name, i));
    end
    tbl.delete();
  endtask

  // One-shot N=3, P=1: steps every second edge, terminal at the fourth step.
  task automatic fill_oneshot();
    tbl.push_back(mk(1,0,0,3,1, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,3,1, 0,0,1,0,0));
    tbl.push_back(mk(0,0,0,3,1, 3,0,1,0,0));
    tbl.push_back(mk(0,0,0,3,1, 3,0,1,0,0));
    tbl.push_back(mk(0,0,0,3,1, 2,0,1,0,0));
    tbl.push_back(mk(0,0,0,3,1, 2,0,1,0,0));
    tbl.push_back(mk(0,0,0,3,1, 1,0,1,0,0));
    tbl.push_back(mk(0,0,0,3,1, 1,0,1,0,0));
    tbl.push_back(mk(0,0,0,3,1, 0,0,1,0,0));
    tbl.push_back(mk(0,0,0,3,1, 0,0,1,1,0));
    tbl.push_back(mk(0,0,0,3,1, 0,0,0,0,1));
    tbl.push_back(mk(0,0,0,3,1, 0,0,0,0,0));
  endtask

  // Reference model state for the scoreboard runs.
  int m_st, m_q, m_pc, m_mode, m_ld, m_ps;
  bit m_dir, m_done;

  function automatic void model_reset();
    m_st = 0; m_q = 0; m_pc = 0; m_mode = 0; m_ld = 0; m_ps = 0;
    m_dir = 1'b0; m_done = 1'b0;
  endfunction

  function automatic vec_t model_vec(input bit st, input bit sp, input int md, input int ld, input int ps);
    bit step = (m_pc == m_ps);
    bit tc   = m_dir ? (m_q == 15) : (m_q == 0);
    return mk(st, sp, md, ld, ps, m_q, m_dir, m_st != 0, (m_st == 2) && !sp && step && tc, m_done);
  endfunction

  function automatic void model_edge(input bit st, input bit sp, input int md, input int ld, input int ps);
    bit step = (m_pc == m_ps);
    bit tc   = m_dir ? (m_q == 15) : (m_q == 0);
    m_done = 1'b0;
    if (m_st == 0) begin
      if (st && !sp) begin m_st = 1; m_mode = md; m_ld = ld; m_ps = ps; end
    end else if (m_st == 1) begin
      if (sp) m_st = 0;
      else begin m_q = m_ld; m_pc = 0; m_dir = (m_mode >= 2); m_st = 2; end
    end else begin
      if (sp) m_st = 0;
      else begin
        if (step) begin
          if (m_mode == 3) m_q = (m_q + 1) % 16;
          else if (tc) begin
            if (m_mode == 0) begin m_st = 0; m_done = 1'b1; end
            else if (m_mode == 1) m_q = m_ld;
            else m_dir = !m_dir;
          end else m_q = m_dir ? m_q + 1 : m_q - 1;
        end
        m_pc = step ? 0 : m_pc + 1;
      end
    end
  endfunction

  task automatic model_cycle(input bit st, input bit sp, input int md, input int ld,
                             input int ps, input string tag);
    drive_check(model_vec(st, sp, md, ld, ps), tag);
    model_edge(st, sp, md, ld, ps);
  endtask

  typedef struct {
    int md; int ld; int ps; bit hold; int len; int stop_at;
  } scen_t;

  initial begin
    scen_t scen[$];
    vec_t  e;

    clr = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0; load_val = 4'd0; presc = 8'd0;
    #12;
    clr = 1'b0;

    // Reset state straight after power-up clear.
    @(negedge clk); #1;
    chk("reset", mk(0,0,0,0,0, 0,0,0,0,0));

    pulse_clr();
    fill_oneshot();
    run_table("oneshot");

    // Periodic N=2, P=0: 2,1,0 repeating, tick with q==0, then stop.
    pulse_clr();
    tbl.push_back(mk(1,0,1,2,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,2,0, 0,0,1,0,0));
    for (int r = 0; r < 2; r++) begin
      tbl.push_back(mk(0,0,1,2,0, 2,0,1,0,0));
      tbl.push_back(mk(0,0,1,2,0, 1,0,1,0,0));
      tbl.push_back(mk(0,0,1,2,0, 0,0,1,1,0));
    end
    tbl.push_back(mk(0,0,1,2,0, 2,0,1,0,0));
    tbl.push_back(mk(0,1,1,2,0, 1,0,1,0,0));
    tbl.push_back(mk(0,0,1,2,0, 1,0,0,0,0));
    run_table("periodic");

    // Ping-pong N=14, P=0: up to 15, hold and turn, down to 0, hold and turn.
    pulse_clr();
    tbl.push_back(mk(1,0,2,14,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,2,14,0, 0,0,1,0,0));
    tbl.push_back(mk(0,0,2,14,0, 14,1,1,0,0));
    tbl.push_back(mk(0,0,2,14,0, 15,1,1,1,0));
    for (int v = 15; v >= 1; v--) tbl.push_back(mk(0,0,2,14,0, v,0,1,0,0));
    tbl.push_back(mk(0,0,2,14,0, 0,0,1,1,0));
    tbl.push_back(mk(0,0,2,14,0, 0,1,1,0,0));
    tbl.push_back(mk(0,0,2,14,0, 1,1,1,0,0));
    run_table("pingpong");

    // Free-run N=14, P=0: 14,15,0,1 with tick on 15, then stop.
    pulse_clr();
    tbl.push_back(mk(1,0,3,14,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,3,14,0, 0,0,1,0,0));
    tbl.push_back(mk(0,0,3,14,0, 14,1,1,0,0));
    tbl.push_back(mk(0,0,3,14,0, 15,1,1,1,0));
    tbl.push_back(mk(0,0,3,14,0, 0,1,1,0,0));
    tbl.push_back(mk(0,0,3,14,0, 1,1,1,0,0));
    tbl.push_back(mk(0,1,3,14,0, 2,1,1,0,0));
    tbl.push_back(mk(0,0,3,14,0, 2,1,0,0,0));
    run_table("freerun");

    // One-shot N=5 with a start during RUN (ignored) and stop on the second RUN cycle.
    pulse_clr();
    tbl.push_back(mk(1,0,0,5,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,5,0, 0,0,1,0,0));
    tbl.push_back(mk(1,0,3,9,7, 5,0,1,0,0));
    tbl.push_back(mk(0,1,0,5,0, 4,0,1,0,0));
    tbl.push_back(mk(0,0,0,5,0, 4,0,0,0,0));
    tbl.push_back(mk(0,0,0,5,0, 4,0,0,0,0));
    run_table("stop");

    // Asynchronous clear in the middle of a free run.
    pulse_clr();
    tbl.push_back(mk(1,0,3,9,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,3,9,0, 0,0,1,0,0));
    tbl.push_back(mk(0,0,3,9,0, 9,1,1,0,0));
    tbl.push_back(mk(0,0,3,9,0, 10,1,1,0,0));
    run_table("clr_run");
    @(negedge clk);
    #2 clr = 1'b1;
    #1 chk("clr_run_async", mk(0,0,0,0,0, 0,0,0,0,0));
    #1 clr = 1'b0;

    // One-shot with load 0 finishes on the first step; clear lands while done is high.
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,1,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,1));
    run_table("oneshot_zero");
    #1 clr = 1'b1;
    #1 chk("clr_done_async", mk(0,0,0,0,0, 0,0,0,0,0));
    #1 clr = 1'b0;

    // After the asynchronous clear a run behaves exactly as from power-up.
    fill_oneshot();
    run_table("after_clr");

    // Scoreboard runs against the reference model.
    pulse_clr();
    model_reset();
    scen.push_back('{md:0, ld:0,  ps:0,   hold:1'b1, len:12,  stop_at:-1});
    scen.push_back('{md:1, ld:0,  ps:2,   hold:1'b0, len:20,  stop_at:-1});
    scen.push_back('{md:0, ld:1,  ps:255, hold:1'b0, len:530, stop_at:-1});
    scen.push_back('{md:2, ld:3,  ps:1,   hold:1'b0, len:40,  stop_at:-1});
    scen.push_back('{md:3, ld:13, ps:0,   hold:1'b0, len:30,  stop_at:25});
    scen.push_back('{md:1, ld:5,  ps:0,   hold:1'b0, len:10,  stop_at:1});
    for (int k = 0; k < 4; k++) begin
      int sa;
      sa = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(2, 59));
      scen.push_back('{md:int'($urandom_range(0, 3)), ld:int'($urandom_range(0, 15)),
                       ps:int'($urandom_range(0, 3)), hold:1'b0, len:60, stop_at:sa});
    end
    for (int s = 0; s < scen.size(); s++) begin
      for (int c = 0; c < scen[s].len; c++) begin
        bit st;
        int md, ld, ps;
        st = (c == 0) || scen[s].hold;
        if (c == 0 || scen[s].hold) begin
          md = scen[s].md; ld = scen[s].ld; ps = scen[s].ps;
        end else begin
          md = int'($urandom_range(0, 3)); ld = int'($urandom_range(0, 15)); ps = int'($urandom_range(0, 255));
        end
        model_cycle(st, c == scen[s].stop_at, md, ld, ps, $sformatf("scen%0d[%0d]", s, c));
      end
      model_cycle(1'b0, 1'b1, 0, 0, 0, $sformatf("scen%0d_stop", s));
      model_cycle(1'b0, 1'b0, 0, 0, 0, $sformatf("scen%0d_idle", s));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
